// File: rtl/ast_field_arbiter.sv
// ---------------------------------------------------------------------------
// ast_field_arbiter
//
// Two-input Avalon-ST video arbiter. One source at a time owns the output for
// a whole field: an optional control packet (type 0xF) followed by a video
// packet (type 0x0). The owner is never switched mid-packet or mid-field.
// Source selection in IDLE follows `mode`: 0 = source 0 only, 1 = source 1
// only, 2 = round-robin per field, 3 = source 0 has priority.
//
// Data path is a zero-latency combinational mux of the granted source; the
// grant, state and counters are registered.
//
// Ports:
//   clock, reset            single clock, asynchronous active-low reset
//   mode[1:0]               arbitration mode, sampled only in IDLE
//   din0_* / din1_*         Avalon-ST sink ports (data/valid/sop/eop/ready)
//   dout_*                  Avalon-ST source port towards the video sink
//   active_src              currently or last granted source
//   busy                    grant held (state is not IDLE)
//   field_count0/1          completed fields forwarded per source (wrap)
//   err_count               discarded out-of-packet beats (saturates at 255)
//
// Build option:
//   AST_FIELD_ARBITER_DROP_IDLE_EN  when defined, sources that cannot be
//   served (not granted, or ineligible / not requesting in IDLE) see
//   ready = 1 and their beats are discarded so upstream FIFOs drain.
// ---------------------------------------------------------------------------
module ast_field_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] din0_data,
  input  logic                  din0_valid,
  input  logic                  din0_startofpacket,
  input  logic                  din0_endofpacket,
  output logic                  din0_ready,
  input  logic [DATA_WIDTH-1:0] din1_data,
  input  logic                  din1_valid,
  input  logic                  din1_startofpacket,
  input  logic                  din1_endofpacket,
  output logic                  din1_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  input  logic                  dout_ready,
  output logic                  active_src,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  field_count0,
  output logic [CNT_WIDTH-1:0]  field_count1,
  output logic [7:0]            err_count
);

`ifdef AST_FIELD_ARBITER_DROP_IDLE_EN
  localparam logic DROP_EN = 1'b1;
`else
  localparam logic DROP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_CTRL         = 3'd1,
    ST_WAIT_VIDEO   = 3'd2,
    ST_VIDEO        = 3'd3,
    ST_AUX          = 3'd4,
    ST_AUX_IN_FIELD = 3'd5
  } state_t;

  // Packet type nibble -> state that forwards that packet. Unknown types are
  // passed through as auxiliary packets, remembering whether a field is open.
  function automatic state_t type_to_state(input logic [3:0] pkt_type,
                                           input logic       in_field);
    state_t st;
    case (pkt_type)
      4'hF:    st = ST_CTRL;
      4'h0:    st = ST_VIDEO;
      default: st = in_field ? ST_AUX_IN_FIELD : ST_AUX;
    endcase
    return st;
  endfunction

  // Winner selection: returns {winner_exists, winner_source}.
  function automatic logic [1:0] arbitrate(input logic [1:0] arb_mode,
                                           input logic       req0,
                                           input logic       req1,
                                           input logic       ptr);
    logic [1:0] res;
    case (arb_mode)
      2'd0:    res = {req0, 1'b0};
      2'd1:    res = {req1, 1'b1};
      2'd2: begin
        if (req0 && req1) begin
          res = {1'b1, ptr};
        end else begin
          res = {req0 | req1, req1};
        end
      end
      2'd3:    res = {req0 | req1, ~req0};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  state_t                state_r;
  state_t                state_s;
  logic                  grant_r;
  logic                  grant_s;
  logic                  rr_ptr_r;
  logic [CNT_WIDTH-1:0]  field_count0_r;
  logic [CNT_WIDTH-1:0]  field_count1_r;
  logic [7:0]            err_count_r;

  logic                  req0_s;
  logic                  req1_s;
  logic                  elig0_s;
  logic                  elig1_s;
  logic [1:0]            arb_s;
  logic [3:0]            win_type_s;

  logic [DATA_WIDTH-1:0] g_data_s;
  logic                  g_valid_s;
  logic                  g_sop_s;
  logic                  g_eop_s;
  logic                  g_ready_s;
  logic                  fwd_s;
  logic                  err_inc_s;
  logic                  field_inc_s;

  // Requests, eligibility and the IDLE arbitration result.
  always_comb begin
    req0_s     = din0_valid & din0_startofpacket;
    req1_s     = din1_valid & din1_startofpacket;
    elig0_s    = (mode != 2'd1);
    elig1_s    = (mode != 2'd0);
    arb_s      = arbitrate(mode, req0_s, req1_s, rr_ptr_r);
    win_type_s = arb_s[0] ? din1_data[3:0] : din0_data[3:0];
  end

  // Mux of the currently granted source.
  always_comb begin
    if (grant_r) begin
      g_data_s  = din1_data;
      g_valid_s = din1_valid;
      g_sop_s   = din1_startofpacket;
      g_eop_s   = din1_endofpacket;
    end else begin
      g_data_s  = din0_data;
      g_valid_s = din0_valid;
      g_sop_s   = din0_startofpacket;
      g_eop_s   = din0_endofpacket;
    end
  end

  // Next-state logic and per-state handshake control.
  always_comb begin
    state_s     = state_r;
    grant_s     = grant_r;
    g_ready_s   = 1'b0;
    fwd_s       = 1'b0;
    err_inc_s   = 1'b0;
    field_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // The SOP beat is only inspected here; the next state forwards it.
        if (arb_s[1]) begin
          grant_s = arb_s[0];
          state_s = type_to_state(win_type_s, 1'b0);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CTRL, ST_AUX, ST_AUX_IN_FIELD, ST_VIDEO: begin
        fwd_s     = 1'b1;
        g_ready_s = dout_ready;
        if (g_valid_s && dout_ready && g_eop_s) begin
          case (state_r)
            ST_CTRL:         state_s = ST_WAIT_VIDEO;
            ST_AUX_IN_FIELD: state_s = ST_WAIT_VIDEO;
            ST_VIDEO: begin
              state_s     = ST_IDLE;
              field_inc_s = 1'b1;
            end
            default:         state_s = ST_IDLE;
          endcase
        end else begin
          state_s = state_r;
        end
      end
      ST_WAIT_VIDEO: begin
        if (g_valid_s) begin
          if (g_sop_s) begin
            // Peek only, like IDLE: the packet state forwards the SOP beat.
            state_s = type_to_state(g_data_s[3:0], 1'b1);
          end else begin
            // Stray beat between packets: swallow it and count it.
            g_ready_s = 1'b1;
            err_inc_s = 1'b1;
          end
        end else begin
          state_s = ST_WAIT_VIDEO;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output port drive: data path and per-source ready.
  always_comb begin
    if (fwd_s) begin
      dout_data          = g_data_s;
      dout_valid         = g_valid_s;
      dout_startofpacket = g_sop_s;
      dout_endofpacket   = g_eop_s;
    end else begin
      dout_data          = {DATA_WIDTH{1'b0}};
      dout_valid         = 1'b0;
      dout_startofpacket = 1'b0;
      dout_endofpacket   = 1'b0;
    end
    if (state_r == ST_IDLE) begin
      // An eligible requester is only ever accepted by being granted.
      din0_ready = DROP_EN & ~(elig0_s & req0_s);
      din1_ready = DROP_EN & ~(elig1_s & req1_s);
    end else if (grant_r) begin
      din0_ready = DROP_EN;
      din1_ready = g_ready_s;
    end else begin
      din0_ready = g_ready_s;
      din1_ready = DROP_EN;
    end
  end

  // State, grant, round-robin pointer and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      grant_r        <= 1'b0;
      rr_ptr_r       <= 1'b0;
      field_count0_r <= {CNT_WIDTH{1'b0}};
      field_count1_r <= {CNT_WIDTH{1'b0}};
      err_count_r    <= 8'd0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      if (field_inc_s) begin
        rr_ptr_r <= ~grant_r;
        if (grant_r) begin
          field_count1_r <= field_count1_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          field_count0_r <= field_count0_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      if (err_inc_s && (err_count_r != 8'd255)) begin
        err_count_r <= err_count_r + 8'd1;
      end
    end
  end

  assign active_src   = grant_r;
  assign busy         = (state_r != ST_IDLE);
  assign field_count0 = field_count0_r;
  assign field_count1 = field_count1_r;
  assign err_count    = err_count_r;

endmodule

// File: tb/tb_ast_field_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ast_field_arbiter
//
// Directed bench for ast_field_arbiter (default build). Sources are driven one
// beat at a time; each accepted beat is compared with what the sink sees.
// Expected values are hand-derived from the field/packet protocol.
// ---------------------------------------------------------------------------
module tb_ast_field_arbiter;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [DW-1:0] din0_data, din1_data;
  logic          din0_valid, din1_valid;
  logic          din0_startofpacket, din1_startofpacket;
  logic          din0_endofpacket, din1_endofpacket;
  logic          din0_ready, din1_ready;
  logic [DW-1:0] dout_data;
  logic          dout_valid, dout_startofpacket, dout_endofpacket;
  logic          dout_ready;
  logic          active_src;
  logic          busy;
  logic [CW-1:0] field_count0, field_count1;
  logic [7:0]    err_count;

  int n_checks = 0;
  int n_errors = 0;
  bit toggle_en = 1'b0;

  always #5 clock = ~clock;

  ast_field_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock              (clock),
    .reset              (reset),
    .mode               (mode),
    .din0_data          (din0_data),
    .din0_valid         (din0_valid),
    .din0_startofpacket (din0_startofpacket),
    .din0_endofpacket   (din0_endofpacket),
    .din0_ready         (din0_ready),
    .din1_data          (din1_data),
    .din1_valid         (din1_valid),
    .din1_startofpacket (din1_startofpacket),
    .din1_endofpacket   (din1_endofpacket),
    .din1_ready         (din1_ready),
    .dout_data          (dout_data),
    .dout_valid         (dout_valid),
    .dout_startofpacket (dout_startofpacket),
    .dout_endofpacket   (dout_endofpacket),
    .dout_ready         (dout_ready),
    .active_src         (active_src),
    .busy               (busy),
    .field_count0       (field_count0),
    .field_count1       (field_count1),
    .err_count          (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int src, input logic v, input logic s, input logic e,
                       input logic [7:0] d);
    if (src == 0) begin
      din0_valid = v; din0_startofpacket = s; din0_endofpacket = e; din0_data = d;
    end else begin
      din1_valid = v; din1_startofpacket = s; din1_endofpacket = e; din1_data = d;
    end
  endtask

  // Present a pending control-packet SOP on a source without waiting.
  task automatic park(input int src);
    drive(src, 1'b1, 1'b1, 1'b0, 8'h0F);
  endtask

  function automatic logic [7:0] beat_data(input int src, input logic [3:0] typ, input int i);
    logic [7:0] d;
    if (i == 0) d = {4'h0, typ};
    else        d = ((src == 0) ? 8'h00 : 8'h80) | 8'(i & 127);
    return d;
  endfunction

  // Called just after a negedge with the beat already driven; returns at the
  // negedge following the accepting clock edge.
  task automatic wait_ack(input int src, input logic [7:0] d, input logic s, input logic e,
                          input bit fwd);
    int   w;
    bit   got;
    logic rdy;
    w = 0;
    got = 1'b0;
    while (!got && w < 20) begin
      if (toggle_en) dout_ready = ~dout_ready;
      #1;
      rdy = (src == 0) ? din0_ready : din1_ready;
      if (toggle_en && dout_valid) chk("ready_follow", rdy, dout_ready);
      if (rdy) begin
        got = 1'b1;
        chk("out_valid", dout_valid, fwd);
        if (fwd) begin
          chk("out_data", dout_data, d);
          chk("out_sop", dout_startofpacket, s);
          chk("out_eop", dout_endofpacket, e);
        end
      end
      @(negedge clock);
      w++;
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  // Send a packet; stop_at >= 0 returns early leaving the source valid.
  task automatic send_pkt(input int src, input logic [3:0] typ, input int len, input int stop_at);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      if (i == stop_at) return;
      d = beat_data(src, typ, i);
      drive(src, 1'b1, (i == 0), (i == len - 1), d);
      wait_ack(src, d, (i == 0), (i == len - 1), 1'b1);
    end
    drive(src, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_junk(input int src, input int n);
    for (int i = 0; i < n; i++) begin
      drive(src, 1'b1, 1'b0, 1'b0, 8'h55);
      wait_ack(src, 8'h55, 1'b0, 1'b0, 1'b0);
    end
    drive(src, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_field(input int src, input int clen, input int vlen);
    send_pkt(src, 4'hF, clen, -1);
    #1 chk("field_owner", active_src, src[0]);
    send_pkt(src, 4'h0, vlen, -1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0;
    mode = 2'd0;
    dout_ready = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 8'hA5);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_dout_sop", dout_startofpacket, 1'b0);
    chk("rst_dout_eop", dout_endofpacket, 1'b0);
    chk("rst_dout_data", dout_data, 8'h00);
    chk("rst_ready0", din0_ready, 1'b0);
    chk("rst_ready1", din1_ready, 1'b0);
    chk("rst_active", active_src, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fc0", field_count0, 16'd0);
    chk("rst_fc1", field_count1, 16'd0);
    chk("rst_err", err_count, 8'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Mode 0: full-size field from source 0, source 1 held off
    mode = 2'd0;
    park(1);
    send_pkt(0, 4'hF, 10, -1);
    #1;
    chk("m0_busy_ctrl", busy, 1'b1);
    chk("m0_hold1", din1_ready, 1'b0);
    send_pkt(0, 4'h0, 1441, -1);
    #1;
    chk("m0_busy_after", busy, 1'b0);
    chk("m0_idle_valid", dout_valid, 1'b0);
    chk("m0_fc0", field_count0, 16'd1);
    chk("m0_fc1", field_count1, 16'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Mode 2: both sources always requesting, alternate 0,1,0,1
    do_reset();
    mode = 2'd2;
    park(1);
    send_field(0, 2, 4);
    park(0);
    send_field(1, 3, 5);
    park(1);
    send_field(0, 2, 4);
    park(0);
    send_field(1, 3, 5);
    #1;
    chk("rr_fc0", field_count0, 16'd2);
    chk("rr_fc1", field_count1, 16'd2);
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Mode 3: source 1 keeps its field, then source 0 takes over
    do_reset();
    mode = 2'd3;
    send_pkt(1, 4'hF, 2, -1);
    park(0);
    send_pkt(1, 4'h0, 4, -1);
    #1 chk("m3_last_src", active_src, 1'b1);
    @(negedge clock);
    #1;
    chk("m3_new_src", active_src, 1'b0);
    chk("m3_busy", busy, 1'b1);
    send_pkt(0, 4'hF, 2, -1);
    send_pkt(0, 4'h0, 2, -1);
    #1;
    chk("m3_fc0", field_count0, 16'd1);
    chk("m3_fc1", field_count1, 16'd1);

    // WAIT_VIDEO stray beats, error counter saturation
    do_reset();
    mode = 2'd0;
    send_pkt(0, 4'hF, 3, -1);
    send_junk(0, 3);
    #1 chk("err_three", err_count, 8'd3);
    send_junk(0, 260);
    #1 chk("err_sat", err_count, 8'd255);
    send_pkt(0, 4'h0, 4, -1);
    #1;
    chk("wv_fc0", field_count0, 16'd1);
    chk("wv_err_hold", err_count, 8'd255);

    // Sink backpressure toggling every cycle
    do_reset();
    mode = 2'd0;
    toggle_en = 1'b1;
    send_field(0, 2, 12);
    toggle_en = 1'b0;
    dout_ready = 1'b1;
    #1 chk("bp_fc0", field_count0, 16'd1);

    // Reset in the middle of a video packet from source 1
    do_reset();
    mode = 2'd1;
    send_field(1, 2, 3);
    send_pkt(1, 4'hF, 2, -1);
    send_pkt(1, 4'h0, 6, 3);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", dout_valid, 1'b0);
    chk("mid_rst_ready1", din1_ready, 1'b0);
    chk("mid_rst_active", active_src, 1'b0);
    chk("mid_rst_fc1", field_count1, 16'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    send_field(1, 2, 3);
    #1;
    chk("post_rst_fc1", field_count1, 16'd1);
    chk("post_rst_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ast_field_arbiter.md
# ast_field_arbiter

Two-input Avalon-ST video arbiter. It sits between two BT.656-to-Avalon-ST converters and a single downstream video sink. It grants the output to one source for one whole field: a control packet (type 0xF) plus the following video packet (type 0x0). Sources are never switched mid-packet or mid-field. Selection is fixed, round-robin or priority according to `mode`, and the block keeps per-source field counters and a protocol-error counter.

## Interface
- `DATA_WIDTH`, 8, symbol width of all data ports; the packet type is `data[3:0]` of the SOP beat.
- `CNT_WIDTH`, 16, width of the per-source field counters.
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-low reset.
- `mode`  in  2  0 = source 0 only; 1 = source 1 only; 2 = round-robin per field; 3 = source 0 has priority.
- `din0_data` / `din1_data`  in  DATA_WIDTH  source symbols.
- `din0_valid` / `din1_valid`  in  1  source beat valid.
- `din0_startofpacket` / `din1_startofpacket`  in  1  source SOP.
- `din0_endofpacket` / `din1_endofpacket`  in  1  source EOP.
- `din0_ready` / `din1_ready`  out  1  backpressure to each source.
- `dout_data`  out  DATA_WIDTH  output symbol.
- `dout_valid`, `dout_startofpacket`, `dout_endofpacket`  out  1  output qualifiers.
- `dout_ready`  in  1  sink ready.
- `active_src`  out  1  currently or last granted source.
- `busy`  out  1  grant is held (state is not IDLE).
- `field_count0` / `field_count1`  out  CNT_WIDTH  completed fields forwarded per source; wraps.
- `err_count`  out  8  discarded out-of-packet beats; saturates at 255.

## Operation
- Avalon-ST, ready latency 0: a beat transfers when valid and ready are both high in the same cycle.
- Output is a combinational mux of the granted source, selected by the registered grant:
  - `dout_* = dinG_*`
  - `dinG_ready = dout_ready`
- A source requests when its `valid` and `startofpacket` are both high.
- States and transitions:
  - **IDLE**
    - `dout_valid` = 0; both readies = 0 (unless `DROP_IDLE_EN` is defined).
    - Arbitrates every cycle; the grant register loads on the cycle a winner exists, and the next state depends on the SOP type nibble.
    - Type 0xF → CTRL. Type 0x0 → VIDEO (field without a control packet). Any other type → AUX.
  - **CTRL**: forwards beats; on the EOP beat → WAIT_VIDEO.
  - **WAIT_VIDEO**
    - Holds the grant.
    - SOP beat of type 0x0 → VIDEO. SOP beat of type 0xF → CTRL. Other SOP types → AUX_IN_FIELD.
    - A non-SOP valid beat is accepted (ready = 1), not forwarded (`dout_valid` = 0), and increments `err_count`.
  - **AUX / AUX_IN_FIELD**: forwards until EOP, then → IDLE or WAIT_VIDEO respectively.
  - **VIDEO**: forwards beats; on the EOP beat → IDLE, `field_countG` += 1, and the round-robin pointer is set to !G.
- Arbitration in IDLE:
  - Mode 0/1: only the named source is eligible; the other is held.
  - Mode 2: the requester at the pointer wins; if only one source requests, it wins.
  - Mode 3: source 0 wins whenever it requests.
- `mode` is sampled only in IDLE; a change mid-field takes effect at the next field.
- A beat with SOP arriving mid-packet (CTRL, VIDEO, AUX) is forwarded unchanged. No repair is attempted.

## Timing
- Zero-cycle data latency (combinational path from source to sink). Grant changes take effect one cycle after the EOP beat.
- A minimum of one IDLE cycle separates consecutive fields, including fields from the same source.
- Reset values:
  - `dout_valid`, `dout_startofpacket`, `dout_endofpacket` = 0; `dout_data` = 0.
  - `din0_ready` = `din1_ready` = 0; `active_src` = 0; `busy` = 0.
  - Counters = 0; state = IDLE; round-robin pointer = 0.
- Reset asserted mid-field drops the grant immediately. The truncated packet is not terminated; the sink must tolerate it.
- `field_count` wraps from 2^CNT_WIDTH−1 to 0. `err_count` holds at 255.
- Simultaneous requests in mode 2 with pointer = 1 → source 1 is granted.

## Configuration
- `AST_FIELD_ARBITER_DROP_IDLE_EN`
  - Defined: the non-granted source (and both sources in IDLE when they are not eligible under `mode`) gets ready = 1. Its beats are discarded, so its upstream FIFO drains instead of filling with stale lines. In IDLE, an eligible requester is still only accepted by being granted.
  - Undefined: the non-granted source sees ready = 0 (pure backpressure).

## Test plan
- Mode 0, source 0 sends a 10-beat control packet (0x0F…) followed by a 1441-beat video packet (0x00…) → identical beats appear on dout; `field_count0` = 1; `busy` falls the cycle after the video EOP.
- Mode 2, both sources continuously request fields → output alternates 0,1,0,1; after 4 fields `field_count0` = `field_count1` = 2; no packet is ever interleaved.
- Mode 3, source 1 is mid-VIDEO when source 0 requests → source 1 finishes its EOP, then source 0 is granted; `active_src` goes 1 → 0.
- WAIT_VIDEO, source 0 drives 3 valid non-SOP beats → `dout_valid` stays 0, `err_count` = 3; a subsequent 0x00 SOP is forwarded.
- `dout_ready` toggled 50% during VIDEO → no beat is lost or duplicated; `din0_ready` equals `dout_ready` every cycle.
- Reset pulled low during VIDEO, then released → all outputs return to 0 and state is IDLE; the next field is granted normally (with `DROP_IDLE_EN` defined, the idle source sees ready = 1 throughout).
